// File: rtl/aer_pkg.sv
// Shared AER widths, packed event layout and dispatcher state type.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package aer_pkg;
    localparam int AER_ADDR_W  = 8;
    localparam int NEURON_ID_W = 4;
    localparam int SYN_ADDR_W  = 4;
    localparam int N_NEURONS   = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_GAP  = 2'd2
    } disp_state_t;

    // Address layout on the wire: {neuron_id, syn_addr}
    typedef struct packed {
        logic [NEURON_ID_W-1:0] neuron_id;
        logic [SYN_ADDR_W-1:0]  syn_addr;
    } aer_evt_t;

    function automatic logic [N_NEURONS-1:0] neuron_onehot(input logic [NEURON_ID_W-1:0] id);
        return N_NEURONS'(1) << id;
    endfunction
endpackage

// File: rtl/aer_spike_receiver_if.sv
// AER receiver bundle: upstream request/ack plus downstream one-hot spike/ack.
// Latency: n/a (wiring only). Optional drop_cnt_out exists with AER_RX_TIMEOUT_EN.
// Backpressure: upstream holds spike_in until ack_out; destination holds off via acks_in.
interface aer_spike_receiver_if;
    import aer_pkg::*;

    logic                   spike_in;
    logic [AER_ADDR_W-1:0]  addr_in;
    logic                   ack_out;
    logic [N_NEURONS-1:0]   spikes_out;
    logic [SYN_ADDR_W-1:0]  syn_addr_out;
    logic [N_NEURONS-1:0]   acks_in;
    logic                   busy;
`ifdef AER_RX_TIMEOUT_EN
    logic [7:0]             drop_cnt_out;

    modport slave  (input  spike_in, addr_in, acks_in,
                    output ack_out, spikes_out, syn_addr_out, busy, drop_cnt_out);
    modport master (output spike_in, addr_in, acks_in,
                    input  ack_out, spikes_out, syn_addr_out, busy, drop_cnt_out);
`else
    modport slave  (input  spike_in, addr_in, acks_in,
                    output ack_out, spikes_out, syn_addr_out, busy);
    modport master (output spike_in, addr_in, acks_in,
                    input  ack_out, spikes_out, syn_addr_out, busy);
`endif
endinterface

// File: rtl/aer_rx_fifo.sv
// Event buffer: DEPTH-entry synchronous FIFO, head visible combinationally.
// Latency: a push is poppable in the next cycle.
// Backpressure: push ignored when full, pop ignored when empty; push+pop together keeps count.
module aer_rx_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push,
    input  logic [W-1:0]           push_dat,
    input  logic                   pop,
    output logic [W-1:0]           pop_dat,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign pop_dat = mem[rd_ptr];

    // Storage has no reset; validity is tracked by count alone
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_dat;
    end

    // Pointers wrap naturally because DEPTH is a power of two
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end
endmodule

// File: rtl/aer_spike_receiver.sv
// AER spike receiver: buffers upstream events, dispatches each as a one-hot spike request.
// Latency: event accepted at edge N into an empty FIFO drives spikes_out after edge N+2.
// Backpressure: no ack while FIFO full; SEND holds until the addressed neuron acks
// (or, with AER_RX_TIMEOUT_EN, until TIMEOUT cycles elapse and the event is dropped).
module aer_spike_receiver
    import aer_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int TIMEOUT    = 15
) (
    input  logic                clk,
    input  logic                reset,
    aer_spike_receiver_if.slave aer
);
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    logic                  ack_q;
    logic                  accept;
    logic                  fifo_pop;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic [CNT_W-1:0]      fifo_count;
    logic [AER_ADDR_W-1:0] fifo_head;
    aer_evt_t              ev_q;
    disp_state_t           state_q;
    disp_state_t           state_d;
    logic [N_NEURONS-1:0]  spikes_q;
    logic [SYN_ADDR_W-1:0] syn_q;
    logic                  out_vld_q;
    logic                  ack_hit;
    logic                  timeout_hit;

    // A request seen during the ack cycle belongs to the previous event, so it is ignored
    assign accept = aer.spike_in && !ack_q && !fifo_full;

    // Only an ack on the addressed neuron counts, and only while the request is visible
    assign ack_hit = out_vld_q && aer.acks_in[ev_q.neuron_id];

    aer_rx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     (AER_ADDR_W)
    ) u_fifo (
        .clk      (clk),
        .reset    (reset),
        .push     (accept),
        .push_dat (aer.addr_in),
        .pop      (fifo_pop),
        .pop_dat  (fifo_head),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .count    (fifo_count)
    );

    // One-cycle accept pulse back to the requester
    always_ff @(posedge clk) begin
        if (reset) ack_q <= 1'b0;
        else       ack_q <= accept;
    end

`ifdef AER_RX_TIMEOUT_EN
    localparam int TMR_W = $clog2(TIMEOUT + 1);

    logic [TMR_W-1:0] timer_q;
    logic [7:0]       drop_cnt_q;

    assign timeout_hit = out_vld_q && !ack_hit && (timer_q == TMR_W'(TIMEOUT - 1));
    assign aer.drop_cnt_out = drop_cnt_q;

    // Counts cycles the request has been visible without a matching ack
    always_ff @(posedge clk) begin
        if (reset || !out_vld_q) timer_q <= '0;
        else                     timer_q <= timer_q + TMR_W'(1);
    end

    // Saturating count of events abandoned by the timeout
    always_ff @(posedge clk) begin
        if (reset)                                 drop_cnt_q <= '0;
        else if (timeout_hit && drop_cnt_q != '1)  drop_cnt_q <= drop_cnt_q + 8'd1;
    end
`else
    // Timeout parameter has no effect in this build; SEND waits forever
    localparam int unused_timeout_p = TIMEOUT;
    assign timeout_hit = 1'b0;
`endif

    // Dispatcher next state: pop in IDLE, hold in SEND, one idle cycle in GAP
    always_comb begin
        state_d  = state_q;
        fifo_pop = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    state_d  = ST_SEND;
                end
            end
            ST_SEND: if (ack_hit || timeout_hit) state_d = ST_GAP;
            ST_GAP:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Dispatcher state and the event being sent
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            ev_q    <= '0;
        end else begin
            state_q <= state_d;
            if (fifo_pop) ev_q <= aer_evt_t'(fifo_head);
        end
    end

    // Registered request: appears one cycle into SEND, cleared the edge SEND ends
    always_ff @(posedge clk) begin
        if (reset || !(state_q == ST_SEND && state_d == ST_SEND)) begin
            spikes_q  <= '0;
            syn_q     <= '0;
            out_vld_q <= 1'b0;
        end else begin
            spikes_q  <= neuron_onehot(ev_q.neuron_id);
            syn_q     <= ev_q.syn_addr;
            out_vld_q <= 1'b1;
        end
    end

    assign aer.ack_out      = ack_q;
    assign aer.spikes_out   = spikes_q;
    assign aer.syn_addr_out = syn_q;
    assign aer.busy         = (fifo_count != '0) || (state_q != ST_IDLE);
endmodule

// File: tb/tb_aer_spike_receiver.sv
// Directed + randomized bench with a queue-based model of accept order and dispatch order.
// Latency: checks accept->ack and accept->spike timing on an isolated event.
// Backpressure: models upstream hold-until-ack and several destination ack behaviours.
module tb_aer_spike_receiver;
    localparam int DEPTH = 4;
    localparam int TMO   = 15;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    aer_spike_receiver_if rif();

    aer_spike_receiver #(.FIFO_DEPTH(DEPTH), .TIMEOUT(TMO)) dut (
        .clk   (clk),
        .reset (reset),
        .aer   (rif)
    );

    int total = 0;
    int bad   = 0;

    // Model state: requests waiting for ack, accepted events awaiting dispatch
    logic [7:0]  src_q[$];
    logic [7:0]  exp_q[$];
    logic [7:0]  disp_log[$];
    logic [7:0]  cur_evt = 8'h00;
    logic [15:0] prev_spk = '0;
    logic [15:0] fixed_acks = '0;
    logic        prev_ack = 1'b0;
    int          ack_mode = 0;   // 0 none, 1 prompt, 2 random delay + noise, 3 fixed pattern
    int          ack_wait = 0;
    int          cyc = 0;
    int          acks_seen = 0;
    int          disp_seen = 0;
    int          last_ack_cyc = -1;
    int          last_disp_cyc = -1;
    int          vis_run = 0;
    int          last_vis_len = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int oh_idx(input logic [15:0] v);
        for (int i = 0; i < 16; i++) if (v[i]) return i;
        return 0;
    endfunction

    function automatic logic [15:0] oh(input logic [7:0] a);
        logic [15:0] r;
        r = 16'h0001 << a[7:4];
        return r;
    endfunction

    // One clock: sample at negedge, update model, drive next inputs
    task automatic step();
        logic [7:0]  e;
        logic [15:0] noise;
        @(negedge clk);
        cyc++;
        if (rif.ack_out === 1'b1) begin
            chk("ack_pulse_width", {31'd0, prev_ack}, 0);
            chk("ack_has_request", src_q.size() > 0, 1);
            if (src_q.size() > 0) exp_q.push_back(src_q.pop_front());
            chk("capacity", exp_q.size() <= DEPTH + 1, 1);
            acks_seen++;
            last_ack_cyc = cyc;
        end
        prev_ack = rif.ack_out;
        if (rif.spikes_out == 16'h0) chk("syn_zero_when_idle", rif.syn_addr_out, 0);
        if (rif.spikes_out != 16'h0) begin
            vis_run++;
            if (prev_spk == 16'h0) begin
                chk("dispatch_expected", exp_q.size() > 0, 1);
                e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'h00;
                cur_evt = e;
                chk("spikes_onehot", rif.spikes_out, oh(e));
                chk("syn_addr", rif.syn_addr_out, e[3:0]);
                disp_log.push_back({4'(oh_idx(rif.spikes_out)), rif.syn_addr_out});
                disp_seen++;
                last_disp_cyc = cyc;
                ack_wait = (ack_mode == 2) ? int'($urandom_range(0, 4)) : 0;
            end else begin
                chk("spikes_stable", rif.spikes_out, oh(cur_evt));
            end
        end else if (prev_spk != 16'h0) begin
            last_vis_len = vis_run;
            vis_run = 0;
        end
        prev_spk = rif.spikes_out;
        // destination side
        noise = (ack_mode == 2) ? 16'($urandom) : 16'h0;
        if (ack_mode == 3) begin
            rif.acks_in = fixed_acks;
        end else if (rif.spikes_out != 16'h0 && ack_mode != 0) begin
            if (ack_wait == 0) rif.acks_in = noise | rif.spikes_out;
            else begin
                ack_wait--;
                rif.acks_in = noise & ~rif.spikes_out;
            end
        end else begin
            rif.acks_in = 16'h0;
        end
        // upstream side: present head request until acked
        rif.spike_in = (src_q.size() > 0);
        rif.addr_in  = (src_q.size() > 0) ? src_q[0] : 8'h00;
    endtask

    task automatic drain(input string tag, input int bound);
        int n = 0;
        while ((src_q.size() > 0 || exp_q.size() > 0 || rif.busy !== 1'b0 ||
                rif.spikes_out != 16'h0) && n < bound) begin
            step();
            n++;
        end
        chk(tag, n < bound, 1);
    endtask

    initial begin
        int d0, a0, n0, n;
        logic [7:0] v;
        rif.spike_in = 1'b0;
        rif.addr_in  = 8'h00;
        rif.acks_in  = 16'h0;

        // Reset state
        repeat (2) step();
        chk("rst_ack", rif.ack_out, 0);
        chk("rst_spikes", rif.spikes_out, 0);
        chk("rst_syn", rif.syn_addr_out, 0);
        chk("rst_busy", rif.busy, 0);
        reset = 1'b0;
        step();

        // Single event: ack one cycle after accept, spike two cycles after that
        ack_mode = 1;
        src_q.push_back(8'h3A);
        step();
        d0 = cyc;
        repeat (4) step();
        chk("single_ack_latency", last_ack_cyc - d0, 1);
        chk("single_spike_latency", last_disp_cyc - d0, 3);
        chk("single_gap_busy", rif.busy, 1);
        chk("single_gap_spikes", rif.spikes_out, 0);
        step();
        chk("single_idle_busy", rif.busy, 0);
        chk("single_vis_len", last_vis_len, 1);
        chk("single_log", disp_log[disp_log.size()-1], 8'h3A);

        // Wrong-neuron ack is ignored; matching ack releases
        ack_mode = 3;
        fixed_acks = 16'h0001;
        src_q.push_back(8'h5C);
        repeat (12) step();
        chk("wrong_ack_hold", rif.spikes_out, 16'h0020);
        chk("wrong_ack_syn", rif.syn_addr_out, 4'hC);
        fixed_acks = 16'h0020;
        repeat (2) step();
        chk("right_ack_release", rif.spikes_out, 0);
        ack_mode = 1;
        drain("wrong_ack_drain", 20);

`ifndef AER_RX_TIMEOUT_EN
        // Burst with no acks: one in SEND plus a full FIFO, sixth requester stalls
        ack_mode = 0;
        a0 = acks_seen;
        n0 = disp_seen;
        for (int i = 0; i < 6; i++) src_q.push_back(8'($urandom));
        repeat (20) step();
        chk("burst_acks", acks_seen - a0, 5);
        chk("burst_stalled_req", src_q.size(), 1);
        chk("burst_no_ack_now", rif.ack_out, 0);
        chk("burst_busy", rif.busy, 1);
        ack_mode = 2;
        drain("burst_drain", 300);
        chk("burst_dispatched", disp_seen - n0, 6);
`endif

        // Wrap: ten sequential addresses through the FIFO, prompt acks
        ack_mode = 1;
        disp_log.delete();
        for (int i = 0; i < 10; i++) src_q.push_back(8'(i));
        drain("wrap_drain", 300);
        chk("wrap_count", disp_log.size(), 10);
        for (int i = 0; i < 10 && i < disp_log.size(); i++) chk("wrap_order", disp_log[i], 8'(i));

        // Randomized traffic with random ack delay and ignored noise bits
        ack_mode = 2;
        n0 = disp_seen;
        for (int i = 0; i < 30; i++) src_q.push_back(8'($urandom));
        drain("random_drain", 1000);
        chk("random_dispatched", disp_seen - n0, 30);

        // Reset mid-SEND with three buffered; a request held across reset is taken after release
        ack_mode = 0;
        a0 = acks_seen;
        for (int i = 0; i < 4; i++) src_q.push_back(8'h80 + 8'(i));
        repeat (12) step();
        chk("pre_rst_acks", acks_seen - a0, 4);
        chk("pre_rst_sending", rif.spikes_out, oh(8'h80));
        src_q.push_back(8'hE7);
        reset = 1'b1;
        rif.spike_in = 1'b1;
        rif.addr_in  = 8'hE7;
        step();
        chk("rst_mid_spikes", rif.spikes_out, 0);
        chk("rst_mid_busy", rif.busy, 0);
        step();
        chk("rst_hold_no_ack", rif.ack_out, 0);
        exp_q.delete();
        reset = 1'b0;
        ack_mode = 1;
        n0 = disp_seen;
        drain("post_rst_drain", 50);
        chk("post_rst_dispatched", disp_seen - n0, 1);
        chk("post_rst_evt", disp_log[disp_log.size()-1], 8'hE7);

`ifdef AER_RX_TIMEOUT_EN
        // No ack: request dropped after TIMEOUT visible cycles, next event follows
        chk("drop_cnt_init", rif.drop_cnt_out, 0);
        ack_mode = 0;
        n0 = disp_seen;
        src_q.push_back(8'h21);
        src_q.push_back(8'h42);
        n = 0;
        while (disp_seen == n0 && n < 20) begin step(); n++; end
        n = 0;
        while (rif.spikes_out != 16'h0 && n < 40) begin step(); n++; end
        chk("timeout_len", last_vis_len, TMO);
        chk("drop_cnt_one", rif.drop_cnt_out, 1);
        n = 0;
        while (disp_seen == n0 + 1 && n < 20) begin step(); n++; end
        chk("after_drop_next", rif.spikes_out, oh(8'h42));
        ack_mode = 1;
        drain("timeout_drain", 60);
        chk("drop_cnt_final", rif.drop_cnt_out, 1);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
